freq_frame_reader: RTL and testbench
====================================

# freq_frame_reader

Output-side collector for the frequency-domain equalizer. It reads the per-bin stream produced by `history_buffer`: Y bins tagged with `o_k_idx`, which arrive with no backpressure. It assembles the bins into complete N-bin frames in a ping-pong buffer and replays each frame in bin order to the downstream IFFT stage over a valid/ready handshake. It flags dropped frames and broken bin sequences.

## Interface
- `W`, 16, sample width of each real/imag component (Q2.14, passed through unchanged)
- `N`, 32, bins per frame (power of two)
- `KW`, 5, bin-index width, log2(N)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_valid`  in  1  input bin valid; always accepted, no ready returned
- `i_Y_re`, `i_Y_im`  in  W each  input bin, signed
- `i_k_idx`  in  KW  input bin index
- `o_valid`  out  1  output bin valid
- `i_ready`  in  1  downstream ready
- `o_Y_re`, `o_Y_im`  out  W each  output bin, signed
- `o_k_idx`  out  KW  output bin index
- `o_last`  out  1  high with bin N-1
- `o_overflow`  out  1  sticky: a frame was dropped because no bank was free
- `o_seq_err`  out  1  sticky: the bin index sequence was broken

## Operation
- Storage is two banks of N complex words, each with a full flag. Pointers `wr_bank` and `rd_bank` are both 0 after reset.
- The write side runs a FSM with three states: IDLE, FILL and DROP.
- IDLE:
  - Only `i_valid` with `i_k_idx`==0 starts a frame. Other indices set `o_seq_err` and are discarded.
  - If `full[wr_bank]` is clear, the bin is written and the FSM moves to FILL with `exp_k`=1.
  - Otherwise `o_overflow` is set and the FSM moves to DROP.
- FILL:
  - With `i_valid` and `i_k_idx`==`exp_k`, the bin is written to `bank[wr_bank][k]` and `exp_k` increments.
  - On k=N-1: set `full[wr_bank]`, toggle `wr_bank`, return to IDLE.
  - Index mismatch: set `o_seq_err` and abandon the partial frame (bank stays not-full). If the mismatching bin has k=0, it is handled as an IDLE start in the same cycle. Otherwise the FSM goes to IDLE.
- DROP: bins are discarded until a k=0 bin arrives, which is then handled as in IDLE.
- Read side:
  - When `full[rd_bank]` is set and the output register is empty or being consumed, the register is loaded with `bank[rd_bank][rd_k]` and `o_valid`=1.
  - `rd_k` advances on each handshake (`o_valid && i_ready`).
  - On the handshake of k=N-1: clear `full[rd_bank]` and toggle `rd_bank`. If the other bank is full, its k=0 is loaded at the same edge, so there is no bubble between frames.
- Outputs hold stable while `o_valid && !i_ready`.
- Data passes through bit-exact: no arithmetic, rounding or saturation.
- Simultaneous events:
  - A bank released by the read side at edge e counts as free for a k=0 write at edge e.
  - Write-complete and read-release on different banks at the same edge both take effect.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - `o_valid`, `o_last`, `o_overflow`, `o_seq_err` = 0.
  - `o_Y_re`, `o_Y_im`, `o_k_idx` = 0.
  - Both banks empty; FSM in IDLE; `exp_k` = `rd_k` = 0.
- Latency: with bin N-1 sampled at edge c, `o_valid` rises after edge c+1 carrying k=0.
- Throughput: one bin per cycle when `i_ready`=1, including frame boundaries.
- Capacity: two full frames buffered. A third frame starting while both banks are full is dropped whole.
- `rst` asserted mid-operation: at the next edge all state returns to reset values. Any partial or buffered frame is lost. The first k=0 after reset starts a new frame normally.

## Test plan
- **Single frame:** after reset, 32 bins `Y_re`=1000+k, `Y_im`=-k, `i_ready`=1 → `o_valid` rises 2 edges after bin 31. The 32 bins come out k=0..31 in order with exact values, and `o_last` is high only at k=31.
- **Backpressure:** one frame with `i_ready` toggling 1,0,1,0 → identical bin sequence; outputs stable on every stalled cycle; each bin emitted exactly once.
- **Back-to-back:** three consecutive frames of constant `Y_re` 1000, 3000, 5000 with `i_ready`=1 → 96 contiguous `o_valid` cycles with no bubble, and the values switch exactly at k=0 of each frame.
- **Overflow:** `i_ready`=0, send three frames (1000, 2000, 3000), then raise `i_ready` → `o_overflow`=1; only the 1000 and 2000 frames are output and nothing from the 3000 frame.
- **Sequence error:** send k=0..9, then a full k=0..31 frame with `Y_re`=7 → `o_seq_err`=1; exactly one frame of 32 bins with value 7 is output.
- **Reset mid-stream:** assert `rst` for one cycle during output bin k=12 → `o_valid`=0 and both flags 0 after that edge; a following clean frame is output with normal latency.

Source files
------------

// File: rtl/freq_frame_reader.sv
// Ping-pong frame collector: assembles N-bin frames from an unthrottled bin stream and replays
// each complete frame in bin order over a valid/ready handshake, flagging drops and bad sequences.
module freq_frame_reader #(
  parameter int unsigned W  = 16,
  parameter int unsigned N  = 32,
  parameter int unsigned KW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_Y_re,
  input  logic signed [W-1:0] i_Y_im,
  input  logic [KW-1:0]       i_k_idx,
  output logic                o_valid,
  input  logic                i_ready,
  output logic signed [W-1:0] o_Y_re,
  output logic signed [W-1:0] o_Y_im,
  output logic [KW-1:0]       o_k_idx,
  output logic                o_last,
  output logic                o_overflow,
  output logic                o_seq_err
);

  typedef enum logic [1:0] {StIdle, StFill, StDrop} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   exp_k_q, exp_k_d;
  logic [KW-1:0]   rd_k_q, rd_k_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;

  logic signed [W-1:0] mem_re [2][N];
  logic signed [W-1:0] mem_im [2][N];

  logic          hs, rel, bank_free, start, we, complete, seq_set, ovf_set, is_zero;
  logic          nxt_bank, load;
  logic [KW-1:0] ld_k;

  // Read side: a bank releases on the handshake of its last bin.
  always_comb begin
    hs       = o_valid && i_ready;
    rel      = hs && o_last;
    nxt_bank = rel ? ~rd_bank_q : rd_bank_q;
    load     = (!o_valid || hs) && full_q[nxt_bank];
    ld_k     = rel ? '0 : rd_k_q;
    rd_bank_d = nxt_bank;
    if (load) begin
      rd_k_d = ld_k + KW'(1);
    end else if (rel) begin
      rd_k_d = '0;
    end else begin
      rd_k_d = rd_k_q;
    end
  end

  // Write side: a bank freed by the reader at this edge is already usable for a new frame.
  always_comb begin
    bank_free = !full_q[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q));
    is_zero   = (i_k_idx == '0);
    state_d   = state_q;
    exp_k_d   = exp_k_q;
    wr_bank_d = wr_bank_q;
    start     = 1'b0;
    we        = 1'b0;
    complete  = 1'b0;
    seq_set   = 1'b0;
    ovf_set   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (i_valid) begin
          if (i_k_idx == exp_k_q) begin
            we      = 1'b1;
            exp_k_d = exp_k_q + KW'(1);
            if (exp_k_q == KW'(N - 1)) begin
              complete  = 1'b1;
              wr_bank_d = ~wr_bank_q;
              state_d   = StIdle;
            end
          end else begin
            seq_set = 1'b1;
            state_d = StIdle;
            start   = is_zero;
          end
        end
      end
      StDrop: start = i_valid && is_zero;
      default: begin
        if (i_valid) begin
          start   = is_zero;
          seq_set = !is_zero;
        end
      end
    endcase
    if (start) begin
      if (bank_free) begin
        we      = 1'b1;
        exp_k_d = KW'(1);
        state_d = StFill;
      end else begin
        ovf_set = 1'b1;
        state_d = StDrop;
      end
    end
    full_d = full_q;
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (complete) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[wr_bank_q][i_k_idx] <= i_Y_re;
      mem_im[wr_bank_q][i_k_idx] <= i_Y_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      exp_k_q    <= '0;
      rd_k_q     <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_Y_re     <= '0;
      o_Y_im     <= '0;
      o_k_idx    <= '0;
      o_overflow <= 1'b0;
      o_seq_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_k_q    <= exp_k_d;
      rd_k_q     <= rd_k_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      o_overflow <= o_overflow | ovf_set;
      o_seq_err  <= o_seq_err | seq_set;
      if (load) begin
        o_valid <= 1'b1;
        o_Y_re  <= mem_re[nxt_bank][ld_k];
        o_Y_im  <= mem_im[nxt_bank][ld_k];
        o_k_idx <= ld_k;
        o_last  <= (ld_k == KW'(N - 1));
      end else if (hs) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_frame_reader.sv
// Bench for freq_frame_reader: a frame-level reference model predicts the output bin stream
// and sticky flags; each scenario task checks its own expectations.
module tb_freq_frame_reader;
  localparam int W  = 16;
  localparam int N  = 32;
  localparam int KW = 5;

  logic                clk = 1'b0;
  logic                rst, i_valid, i_ready;
  logic signed [W-1:0] i_Y_re, i_Y_im;
  logic [KW-1:0]       i_k_idx;
  logic                o_valid, o_last, o_overflow, o_seq_err;
  logic signed [W-1:0] o_Y_re, o_Y_im;
  logic [KW-1:0]       o_k_idx;

  always #5 clk = ~clk;

  freq_frame_reader #(.W(W), .N(N), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_Y_re    (i_Y_re),
    .i_Y_im    (i_Y_im),
    .i_k_idx   (i_k_idx),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_Y_re    (o_Y_re),
    .o_Y_im    (o_Y_im),
    .o_k_idx   (o_k_idx),
    .o_last    (o_last),
    .o_overflow(o_overflow),
    .o_seq_err (o_seq_err)
  );

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    int                  k;
    bit                  last;
  } bin_t;

  bin_t exp_q[$], got_q[$], part_q[$];
  bit   collecting, dropping, m_ovf, m_seq;
  int   unreleased;
  int   errors = 0, checks = 0;
  int   stall_err, run, max_run;
  bit   prev_stall;
  logic signed [W-1:0] p_re, p_im;
  logic [KW-1:0]       p_k;
  logic                p_last;

  function automatic void model_reset();
    collecting = 0; dropping = 0; unreleased = 0; m_ovf = 0; m_seq = 0;
    part_q.delete();
    while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
  endfunction

  // Frame-level view: a frame is kept only if it arrives whole while fewer than two
  // complete frames are still awaiting their last handshake.
  function automatic void model_write();
    bin_t b;
    int   k;
    if (!i_valid) return;
    k = int'(i_k_idx);
    b.re = i_Y_re; b.im = i_Y_im; b.k = k; b.last = (k == N - 1);
    if (collecting && k == part_q.size()) begin
      part_q.push_back(b);
      if (part_q.size() == N) begin
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        unreleased++;
        collecting = 0;
        part_q.delete();
      end
      return;
    end
    if (collecting || (k != 0 && !dropping)) m_seq = 1;
    collecting = 0;
    part_q.delete();
    if (k == 0) begin
      if (unreleased < 2) begin
        collecting = 1; dropping = 0; part_q.push_back(b);
      end else begin
        m_ovf = 1; dropping = 1;
      end
    end
  endfunction

  task automatic cycle();
    bin_t b;
    bit   v, rdy;
    v = o_valid; rdy = i_ready;
    if (prev_stall && (o_valid !== 1'b1 || o_Y_re !== p_re || o_Y_im !== p_im ||
                       o_k_idx !== p_k || o_last !== p_last)) stall_err++;
    run = v ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (v && rdy) begin
      b.re = o_Y_re; b.im = o_Y_im; b.k = int'(o_k_idx); b.last = o_last;
      if (got_q.size() < exp_q.size() && exp_q[got_q.size()].last) unreleased--;
      got_q.push_back(b);
    end
    prev_stall = v && !rdy && !rst;
    p_re = o_Y_re; p_im = o_Y_im; p_k = o_k_idx; p_last = o_last;
    if (rst) model_reset();
    else model_write();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bin(input int k, input int re, input int im);
    i_valid = 1'b1;
    i_k_idx = KW'(k);
    i_Y_re  = W'(re);
    i_Y_im  = W'(im);
    cycle();
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input int re);
    for (int k = 0; k < N; k++) send_bin(k, re, int'($urandom_range(0, 65535)));
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (got_q.size() >= exp_q.size() && !o_valid) break;
      cycle();
    end
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic clear();
    got_q.delete(); exp_q.delete();
    stall_err = 0; max_run = 0; run = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_Y_re = '0; i_Y_im = '0; i_k_idx = '0;
    prev_stall = 0;
    cycle(); cycle();
    rst = 1'b0;
    checks += 7;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", o_last); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
    if (o_seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq got=%b exp=0", o_seq_err); end
    if (o_Y_re !== '0) begin errors++; $display("FAIL reset_re got=%0d exp=0", o_Y_re); end
    if (o_Y_im !== '0) begin errors++; $display("FAIL reset_im got=%0d exp=0", o_Y_im); end
    if (o_k_idx !== '0) begin errors++; $display("FAIL reset_k got=%0d exp=0", o_k_idx); end
  endtask

  task automatic test_single();
    clear();
    i_ready = 1'b1;
    for (int k = 0; k < N; k++) send_bin(k, 1000 + k, -k);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", o_valid); end
    cycle();
    checks++;
    if (o_valid !== 1'b1 || o_k_idx !== '0) begin
      errors++; $display("FAIL single_latency got v=%b k=%0d exp v=1 k=0", o_valid, o_k_idx);
    end
    drain();
    checks++;
    if (got_q.size() != N) begin errors++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), N); end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      checks++;
      if (got_q[i].re !== W'(1000 + i) || got_q[i].im !== W'(-i) || got_q[i].k != i ||
          got_q[i].last != (i == N - 1)) begin
        errors++;
        $display("FAIL single_bin%0d got re=%0d im=%0d k=%0d last=%0b exp re=%0d im=%0d", i,
                 got_q[i].re, got_q[i].im, got_q[i].k, got_q[i].last, 1000 + i, -i);
      end
    end
  endtask

  task automatic test_backpressure();
    clear();
    i_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      i_ready = ~i_ready;
      send_bin(k, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    for (int i = 0; i < 3 * N; i++) begin
      i_ready = ~i_ready;
      cycle();
    end
    drain();
    checks += 2;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    if (got_q.size() != N) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), N); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im ||
          got_q[i].k != exp_q[i].k || got_q[i].last != exp_q[i].last) begin
        errors++;
        $display("FAIL bp_bin%0d got re=%0d k=%0d exp re=%0d k=%0d", i, got_q[i].re, got_q[i].k,
                 exp_q[i].re, exp_q[i].k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vals[3] = '{1000, 3000, 5000};
    clear();
    i_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(vals[f]);
    drain();
    checks += 2;
    if (max_run != 3 * N) begin errors++; $display("FAIL b2b_run got=%0d exp=%0d", max_run, 3 * N); end
    if (got_q.size() != 3 * N) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 3 * N);
    end
    for (int i = 0; i < got_q.size() && i < 3 * N; i++) begin
      checks++;
      if (got_q[i].re !== W'(vals[i / N]) || got_q[i].k != i % N ||
          got_q[i].im !== exp_q[i].im) begin
        errors++;
        $display("FAIL b2b_bin%0d got re=%0d k=%0d exp re=%0d k=%0d", i, got_q[i].re, got_q[i].k,
                 vals[i / N], i % N);
      end
    end
  endtask

  task automatic test_overflow();
    clear();
    i_ready = 1'b0;
    send_frame(1000);
    send_frame(2000);
    send_frame(3000);
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", o_overflow); end
    drain();
    checks++;
    if (got_q.size() != 2 * N) begin
      errors++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), 2 * N);
    end
    for (int i = 0; i < got_q.size() && i < 2 * N; i++) begin
      checks++;
      if (got_q[i].re !== W'(i < N ? 1000 : 2000) || got_q[i].k != i % N) begin
        errors++;
        $display("FAIL ovf_bin%0d got re=%0d k=%0d exp re=%0d", i, got_q[i].re, got_q[i].k,
                 i < N ? 1000 : 2000);
      end
    end
  endtask

  task automatic test_seq_err();
    clear();
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) send_bin(k, 500, 0);
    send_frame(7);
    checks++;
    if (o_seq_err !== 1'b1) begin errors++; $display("FAIL seq_flag got=%b exp=1", o_seq_err); end
    drain();
    checks++;
    if (got_q.size() != N) begin errors++; $display("FAIL seq_count got=%0d exp=%0d", got_q.size(), N); end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      checks++;
      if (got_q[i].re !== W'(7) || got_q[i].k != i) begin
        errors++; $display("FAIL seq_bin%0d got re=%0d k=%0d exp re=7 k=%0d", i, got_q[i].re,
                           got_q[i].k, i);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    clear();
    i_ready = 1'b1;
    send_bin(5, 0, 0);
    send_frame(4321);
    for (int i = 0; i < 100; i++) begin
      if (o_valid && o_k_idx == KW'(12)) begin found = 1; break; end
      cycle();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_reach got=none exp=bin12"); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks += 3;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", o_overflow); end
    if (o_seq_err !== 1'b0) begin errors++; $display("FAIL midrst_seq got=%b exp=0", o_seq_err); end
    for (int i = 0; i < 4; i++) cycle();
    clear();
    send_frame(2222);
    cycle();
    checks++;
    if (o_valid !== 1'b1 || o_k_idx !== '0) begin
      errors++; $display("FAIL midrst_latency got v=%b k=%0d exp v=1 k=0", o_valid, o_k_idx);
    end
    drain();
    checks++;
    if (got_q.size() != N) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), N); end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      checks++;
      if (got_q[i].re !== W'(2222) || got_q[i].k != i || got_q[i].im !== exp_q[i].im) begin
        errors++; $display("FAIL midrst_bin%0d got re=%0d k=%0d exp re=2222 k=%0d", i,
                           got_q[i].re, got_q[i].k, i);
      end
    end
  endtask

  task automatic test_random();
    int len;
    clear();
    for (int f = 0; f < 14; f++) begin
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N - 1)) : N;
      for (int k = 0; k < len; k++) begin
        while ($urandom_range(0, 5) == 0) begin
          i_ready = ($urandom_range(0, 9) < 6);
          cycle();
        end
        i_ready = ($urandom_range(0, 9) < 6);
        send_bin(k, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      end
    end
    drain();
    checks += 4;
    if (stall_err != 0) begin errors++; $display("FAIL rnd_stable got=%0d exp=0", stall_err); end
    if (o_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf got=%b exp=%b", o_overflow, m_ovf); end
    if (o_seq_err !== m_seq) begin errors++; $display("FAIL rnd_seq got=%b exp=%b", o_seq_err, m_seq); end
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].re !== exp_q[i].re || got_q[i].im !== exp_q[i].im ||
          got_q[i].k != exp_q[i].k || got_q[i].last != exp_q[i].last) begin
        errors++;
        $display("FAIL rnd_bin%0d got re=%0d im=%0d k=%0d exp re=%0d im=%0d k=%0d", i,
                 got_q[i].re, got_q[i].im, got_q[i].k, exp_q[i].re, exp_q[i].im, exp_q[i].k);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_seq_err();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
